// File: rtl/balance_round_ctrl.sv
// ---------------------------------------------------------------------------
// balance_round_ctrl
// Game-round controller for the two-lever balance game. After a start pulse
// it arms for one cycle (so the level register's nivel settles), then runs a
// timed round. Lever difference is evaluated once per tick against a
// level-dependent tolerance. HOLD_TICKS consecutive in-balance ticks win the
// round. Running out of time first loses it.
//
// Optional build macro: BALANCE_PENALTY_EN
//   Each 1->0 drop of in_balance costs one extra second. Adds penalty_count.
//
// Ports
//   clock         in   system clock
//   reset         in   asynchronous, active-high reset
//   start_game    in   one-cycle start / replay pulse
//   nivel         in   [1:0]  latched difficulty (0 easiest .. 3 hardest)
//   alavanca1     in   [15:0] signed lever 1 position
//   alavanca2     in   [15:0] signed lever 2 position
//   state         out  [2:0]  0 IDLE, 1 ARM, 2 PLAYING, 3 WIN, 4 LOSE
//   in_balance    out  tolerance compare result of the last tick
//   hold_count    out  [15:0] consecutive in-balance ticks
//   time_left     out  [7:0]  seconds remaining
//   round_win     out  one-cycle pulse on entry to WIN
//   round_lose    out  one-cycle pulse on entry to LOSE
//   game_over     out  high while in WIN or LOSE
//   penalty_count out  [7:0]  penalties this round (BALANCE_PENALTY_EN only)
// ---------------------------------------------------------------------------
module balance_round_ctrl #(
    parameter int unsigned CLK_HZ        = 50000000,
    parameter int unsigned TICK_HZ       = 100,
    parameter int unsigned ROUND_SECONDS = 30,
    parameter int unsigned HOLD_TICKS    = 300,
    parameter int unsigned TOL0          = 4096,
    parameter int unsigned TOL1          = 2048,
    parameter int unsigned TOL2          = 1024,
    parameter int unsigned TOL3          = 512
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start_game,
    input  logic [1:0]         nivel,
    input  logic signed [15:0] alavanca1,
    input  logic signed [15:0] alavanca2,
    output logic [2:0]         state,
    output logic               in_balance,
    output logic [15:0]        hold_count,
    output logic [7:0]         time_left,
    output logic               round_win,
    output logic               round_lose,
    output logic               game_over
`ifdef BALANCE_PENALTY_EN
    ,
    output logic [7:0]         penalty_count
`endif
);

    localparam int unsigned PRESC_MAX = CLK_HZ / TICK_HZ - 1;
    localparam int unsigned PRESC_W   = (PRESC_MAX > 0) ? $clog2(PRESC_MAX + 1) : 1;
    localparam int unsigned SEC_W     = (TICK_HZ > 1) ? $clog2(TICK_HZ) : 1;
    localparam int unsigned DIFF_W    = 17;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARM     = 3'd1,
        S_PLAYING = 3'd2,
        S_WIN     = 3'd3,
        S_LOSE    = 3'd4
    } state_t;

    state_t              r_state;
    logic [PRESC_W-1:0]  r_presc;
    logic [SEC_W-1:0]    r_sec;
    logic [DIFF_W-1:0]   r_tol;
    logic                r_in_balance;
    logic [15:0]         r_hold;
    logic [7:0]          r_time_left;
    logic                r_round_win;
    logic                r_round_lose;
    logic                r_game_over;
    logic [7:0]          r_penalty_cnt;

    logic                w_tick;
    logic [DIFF_W-1:0]   w_diff;
    logic [DIFF_W-1:0]   w_absdiff;
    logic                w_in_bal;
    logic [15:0]         w_hold_nxt;
    logic                w_sec_wrap;
    logic [SEC_W-1:0]    w_sec_nxt;
    logic                w_penalty;
    logic [1:0]          w_dec;
    logic [7:0]          w_time_nxt;
    logic                w_win;
    logic                w_lose;

    // Sign-extend both levers to 17 bits so the difference never overflows.
    assign w_diff    = {alavanca1[15], alavanca1} - {alavanca2[15], alavanca2};
    assign w_absdiff = w_diff[DIFF_W-1] ? (DIFF_W'(0) - w_diff) : w_diff;
    assign w_in_bal  = (w_absdiff <= r_tol);

    assign w_tick    = (r_state == S_PLAYING) && (r_presc == PRESC_W'(PRESC_MAX));

    // Consecutive-hold counter: saturate at target, clear on any miss.
    assign w_hold_nxt = !w_in_bal ? 16'd0 :
                        (r_hold >= 16'(HOLD_TICKS)) ? r_hold : r_hold + 16'd1;

    assign w_sec_wrap = (r_sec == SEC_W'(TICK_HZ - 1));
    assign w_sec_nxt  = w_sec_wrap ? SEC_W'(0) : r_sec + SEC_W'(1);

`ifdef BALANCE_PENALTY_EN
    assign w_penalty = r_in_balance & ~w_in_bal;
`else
    assign w_penalty = 1'b0;
`endif

    // Second boundary and penalty can coincide; saturate time_left at zero.
    assign w_dec      = 2'(w_sec_wrap) + 2'(w_penalty);
    assign w_time_nxt = (r_time_left <= 8'(w_dec)) ? 8'd0 : r_time_left - 8'(w_dec);

    assign w_win  = (w_hold_nxt == 16'(HOLD_TICKS));
    assign w_lose = (w_time_nxt == 8'd0);

    // Round FSM with all counters and outputs registered.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_presc       <= '0;
            r_sec         <= '0;
            r_tol         <= DIFF_W'(TOL0);
            r_in_balance  <= 1'b0;
            r_hold        <= 16'd0;
            r_time_left   <= 8'(ROUND_SECONDS);
            r_round_win   <= 1'b0;
            r_round_lose  <= 1'b0;
            r_game_over   <= 1'b0;
            r_penalty_cnt <= 8'd0;
        end else begin
            r_round_win  <= 1'b0;
            r_round_lose <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_game) begin
                        r_state <= S_ARM;
                    end
                end
                S_ARM: begin
                    // nivel is stable by now; lock its tolerance for the round.
                    case (nivel)
                        2'd0:    r_tol <= DIFF_W'(TOL0);
                        2'd1:    r_tol <= DIFF_W'(TOL1);
                        2'd2:    r_tol <= DIFF_W'(TOL2);
                        default: r_tol <= DIFF_W'(TOL3);
                    endcase
                    r_time_left   <= 8'(ROUND_SECONDS);
                    r_hold        <= 16'd0;
                    r_presc       <= '0;
                    r_sec         <= '0;
                    r_in_balance  <= 1'b0;
                    r_penalty_cnt <= 8'd0;
                    r_game_over   <= 1'b0;
                    r_state       <= S_PLAYING;
                end
                S_PLAYING: begin
                    if (w_tick) begin
                        r_presc      <= '0;
                        r_in_balance <= w_in_bal;
                        r_hold       <= w_hold_nxt;
                        r_sec        <= w_sec_nxt;
                        r_time_left  <= w_time_nxt;
                        if (w_penalty && (r_penalty_cnt != 8'hFF)) begin
                            r_penalty_cnt <= r_penalty_cnt + 8'd1;
                        end
                        // Win takes priority over a simultaneous timeout.
                        if (w_win) begin
                            r_state     <= S_WIN;
                            r_round_win <= 1'b1;
                            r_game_over <= 1'b1;
                        end else if (w_lose) begin
                            r_state      <= S_LOSE;
                            r_round_lose <= 1'b1;
                            r_game_over  <= 1'b1;
                        end
                    end else begin
                        r_presc <= r_presc + PRESC_W'(1);
                    end
                end
                S_WIN, S_LOSE: begin
                    if (start_game) begin
                        r_state     <= S_ARM;
                        r_game_over <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_game_over <= 1'b0;
                end
            endcase
        end
    end

    assign state      = r_state;
    assign in_balance = r_in_balance;
    assign hold_count = r_hold;
    assign time_left  = r_time_left;
    assign round_win  = r_round_win;
    assign round_lose = r_round_lose;
    assign game_over  = r_game_over;
`ifdef BALANCE_PENALTY_EN
    assign penalty_count = r_penalty_cnt;
`else
    logic w_unused;
    assign w_unused = ^r_penalty_cnt;
`endif

endmodule
